por_event_recorder: RTL and testbench

POR_EVENT_RECORDER -- requirements
Module: por_event_recorder

---
 rtl/por_event_recorder.sv | 117 +++++++++++
 tb/tb_por_event_recorder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/por_event_recorder.sv
// por_event_recorder: timestamps PoR hash strobes into a FIFO of 64-bit records.
// Latency: a pushed record is visible on rd_data one cycle after its strobe (no fall-through).
// Backpressure: rd_valid/rd_ready handshake; a push into a full FIFO without a pop is dropped and counted.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   veto_in            FPT veto level; rising edges are counted on veto_edges
//   attention_level    2-bit attention level captured with each record
//   por_hash_in        32-bit hash word, qualified by por_valid_in
//   rd_valid/rd_ready  record read handshake; rd_data = {timestamp, attention, hash}
//   clr_ovf            clears overflow and drop_count (a same-cycle drop wins)
//   fill_level         occupancy 0..DEPTH
//   overflow           sticky drop flag
//   drop_count         saturating count of dropped records
//   veto_edges         wrapping count of veto_in rising edges
module por_event_recorder #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        veto_in,
  input  logic [1:0]  attention_level,
  input  logic [31:0] por_hash_in,
  input  logic        por_valid_in,
  input  logic        rd_ready,
  input  logic        clr_ovf,
  output logic        rd_valid,
  output logic [63:0] rd_data,
  output logic [6:0]  fill_level,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic [15:0] veto_edges
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [6:0] FULL_LVL = 7'(DEPTH);

  logic [TS_W-1:0] ts;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [6:0]      count;
  logic [63:0]     mem [DEPTH];
  logic            veto_q;

  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [63:0]     rec;

  assign rec  = {ts, attention_level, por_hash_in};
  assign full = (count == FULL_LVL);
  assign pop  = rd_valid && rd_ready;
  // When full, a same-cycle pop frees the slot the write lands in: wr_ptr
  // equals rd_ptr, the old entry is presented this cycle and overwritten at
  // the edge, and both pointers advance together.
  assign push = por_valid_in && (!full || pop);
  assign drop = por_valid_in && full && !pop;

  // Outputs derive only from registered state.
  assign rd_valid   = (count != 7'd0);
  assign rd_data    = mem[rd_ptr];
  assign fill_level = count;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      veto_q     <= 1'b0;
      veto_edges <= '0;
    end else begin
      ts     <= ts + TS_W'(1);
      veto_q <= veto_in;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + 7'd1;
      end else if (pop && !push) begin
        count <= count - 7'd1;
      end

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf) begin
          drop_count <= 8'd1;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end else if (clr_ovf) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end

      if (veto_in && !veto_q) begin
        veto_edges <= veto_edges + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_por_event_recorder.sv
// tb_por_event_recorder: directed checks of por_event_recorder.
// Latency: inputs driven 1 ns after each rising edge, outputs sampled at the same point.
// Backpressure: exercised via rd_ready patterns and full-FIFO pushes.
module tb_por_event_recorder;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        veto_in;
  logic [1:0]  attention_level;
  logic [31:0] por_hash_in;
  logic        por_valid_in;
  logic        rd_ready;
  logic        clr_ovf;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [6:0]  fill_level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [15:0] veto_edges;

  int          n_chk;
  int          n_err;
  logic [29:0] tb_ts;
  logic [63:0] exp_q [$];
  logic [63:0] held;

  por_event_recorder #(.DEPTH(DEPTH), .TS_W(30)) dut (
    .clk             (clk),
    .rst             (rst),
    .veto_in         (veto_in),
    .attention_level (attention_level),
    .por_hash_in     (por_hash_in),
    .por_valid_in    (por_valid_in),
    .rd_ready        (rd_ready),
    .clr_ovf         (clr_ovf),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .fill_level      (fill_level),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .veto_edges      (veto_edges)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tb_ts = tb_ts + 30'd1;
  endtask

  // One cycle of stimulus; the expected-record queue follows the FIFO rules.
  task automatic cyc(input logic v, input logic [31:0] h, input logic [1:0] a, input logic r);
    logic do_pop;
    logic do_push;
    por_valid_in    = v;
    por_hash_in     = h;
    attention_level = a;
    rd_ready        = r;
    do_pop  = (exp_q.size() > 0) && r;
    do_push = v && ((exp_q.size() < DEPTH) || do_pop);
    if (do_push) exp_q.push_back({tb_ts, a, h});
    if (do_pop) void'(exp_q.pop_front());
    tick();
    por_valid_in = 1'b0;
    rd_ready     = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_data", rd_data, exp_q[0]);
      cyc(1'b0, 32'h0, 2'd0, 1'b1);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    tb_ts = '0;
    rst = 1'b1;
    veto_in = 1'b0;
    attention_level = 2'd0;
    por_hash_in = 32'h0;
    por_valid_in = 1'b0;
    rd_ready = 1'b0;
    clr_ovf = 1'b0;

    tick();
    tick();
    tb_ts = '0;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_veto", veto_edges, 0);
    rst = 1'b0;

    // Single push at cycle 5.
    repeat (5) tick();
    chk("sp_pre_valid", rd_valid, 0);
    cyc(1'b1, 32'hDEADBEEF, 2'd2, 1'b0);
    chk("sp_valid", rd_valid, 1);
    chk("sp_data", rd_data, 64'h0000_0016_DEAD_BEEF);
    chk("sp_fill", fill_level, 1);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    chk("sp_pop_valid", rd_valid, 0);
    chk("sp_pop_fill", fill_level, 0);

    // Fill and overflow: 18 strobes, no reads.
    for (int i = 0; i < 18; i++) cyc(1'b1, 32'hA000_0000 + i, 2'(i), 1'b0);
    chk("ovf_fill", fill_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_first_hash", rd_data[31:0], 32'hA000_0000);
    drain(15);
    chk("ovf_last_hash", rd_data[31:0], 32'hA000_000F);
    drain(1);
    chk("ovf_empty_fill", fill_level, 0);
    chk("ovf_empty_valid", rd_valid, 0);

    // Clear, then clear coinciding with a drop.
    clr_ovf = 1'b1;
    cyc(1'b0, 32'h0, 2'd0, 1'b0);
    clr_ovf = 1'b0;
    chk("clr_flag", overflow, 0);
    chk("clr_drop", drop_count, 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'hB000_0000 + i, 2'd1, 1'b0);
    chk("clr_full_no_ovf", overflow, 0);
    clr_ovf = 1'b1;
    cyc(1'b1, 32'hBAD0_BAD0, 2'd0, 1'b0);
    clr_ovf = 1'b0;
    chk("clr_drop_wins_flag", overflow, 1);
    chk("clr_drop_wins_cnt", drop_count, 1);

    // Full with simultaneous push and pop.
    chk("fpp_oldest", rd_data[31:0], 32'hB000_0000);
    cyc(1'b1, 32'hF00D_F00D, 2'd3, 1'b1);
    chk("fpp_fill", fill_level, 16);
    chk("fpp_drop", drop_count, 1);
    chk("fpp_next", rd_data[31:0], 32'hB000_0001);
    drain(15);
    chk("fpp_last_hash", rd_data[31:0], 32'hF00D_F00D);
    drain(1);
    chk("fpp_empty", fill_level, 0);

    // Non-full simultaneous push and pop.
    cyc(1'b1, 32'h1111_1111, 2'd1, 1'b0);
    cyc(1'b1, 32'h2222_2222, 2'd2, 1'b1);
    chk("nfpp_fill", fill_level, 1);
    chk("nfpp_data", rd_data[31:0], 32'h2222_2222);
    drain(1);

    // Backpressure 1,0,1.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC000_0000 + i, 2'd0, 1'b0);
    chk("bp_first", rd_data[31:0], 32'hC000_0000);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    held = rd_data;
    chk("bp_second", rd_data[31:0], 32'hC000_0001);
    cyc(1'b0, 32'h0, 2'd0, 1'b0);
    chk("bp_hold", rd_data, held);
    chk("bp_hold_fill", fill_level, 2);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    chk("bp_third", rd_data[31:0], 32'hC000_0002);
    chk("bp_fill", fill_level, 1);
    drain(1);
    chk("bp_empty", fill_level, 0);

    // drop_count saturation.
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'hD000_0000 + i, 2'd0, 1'b0);
    for (int i = 0; i < 260; i++) cyc(1'b1, 32'hEEEE_0000 + i, 2'd0, 1'b0);
    chk("sat_drop", drop_count, 255);
    chk("sat_fill", fill_level, 16);

    // Veto edges: high 3, low 1, high 1.
    veto_in = 1'b1;
    repeat (3) tick();
    veto_in = 1'b0;
    tick();
    veto_in = 1'b1;
    tick();
    veto_in = 1'b0;
    tick();
    chk("veto_edges", veto_edges, 2);

    // Reset mid-operation, with a push, read and clear all requested.
    rst = 1'b1;
    por_valid_in = 1'b1;
    por_hash_in = 32'h5555_5555;
    rd_ready = 1'b1;
    clr_ovf = 1'b1;
    tick();
    rst = 1'b0;
    por_valid_in = 1'b0;
    rd_ready = 1'b0;
    clr_ovf = 1'b0;
    exp_q.delete();
    chk("rst2_rd_valid", rd_valid, 0);
    chk("rst2_fill", fill_level, 0);
    chk("rst2_overflow", overflow, 0);
    chk("rst2_drop", drop_count, 0);
    chk("rst2_veto", veto_edges, 0);
    tick();
    chk("rst2_no_push", fill_level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
